// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Types and constants shared by the AXI4 burst loopback slice.
// - addr_t / data_t: default-width address (word index) and data types.
// - burst_e / resp_e: AXI burst type and response encodings.
// - mst_state_e / slv_state_e: state encodings for the master and slave FSMs.
// - DEF_*: default parameter values used by every module of the slice.
// ---------------------------------------------------------------------------
package axi_pkg;

  localparam int unsigned  DEF_ADDR_W    = 32;
  localparam int unsigned  DEF_DATA_W    = 32;
  localparam int unsigned  DEF_BURST_LEN = 4;
  localparam int unsigned  DEF_MEM_DEPTH = 256;
  localparam logic [31:0]  DEF_BASE_ADDR = 32'h4;
  localparam logic [31:0]  DEF_BASE_DATA = 32'hdeadbeef;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } mst_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_BRESP,
    S_RDATA
  } slv_state_e;

endpackage

// File: rtl/axi_if.sv
// ---------------------------------------------------------------------------
// axi_if
// AXI4 channel bundle (AW, W, B, AR, R subset) plus the shared clock and
// active-low reset. The master modport drives requests and write data; the
// slave modport drives readies, responses and read data.
// ---------------------------------------------------------------------------
interface axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic aclk,
  input logic areset_n
);

  // Write address
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  // Write data
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // Write response
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // Read address
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  // Read data
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    input  aclk, areset_n,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  aclk, areset_n,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_master.sv
// ---------------------------------------------------------------------------
// axi_master
// Fixed-burst AXI4 traffic generator. start_write issues one INCR burst of
// BURST_LEN beats (data BASE_DATA+beat) at BASE_ADDR; start_read reads the
// same burst back into a local capture array.
// Ports:
//   bus                    axi_if master modport (also supplies clock/reset)
//   start_write/start_read one-cycle launch pulses, honoured only in IDLE
//   busy                   FSM not idle
//   write_done/read_done   one-cycle pulses after the B / last R handshake
//   resp                   last bresp/rresp received
//   dbg_idx/dbg_data       combinational peek into the capture array
// ---------------------------------------------------------------------------
module axi_master
  import axi_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                BURST_LEN = DEF_BURST_LEN,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [DATA_W-1:0] BASE_DATA = DATA_W'(DEF_BASE_DATA),
  parameter int                MEM_DEPTH = DEF_MEM_DEPTH
) (
  axi_if.master             bus,
  input  logic              start_write,
  input  logic              start_read,
  output logic              busy,
  output logic              write_done,
  output logic              read_done,
  output logic [1:0]        resp,
  input  logic [7:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [2:0] SIZE      = 3'($clog2(DATA_W / 8));

  mst_state_e        state_q, state_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        resp_q, resp_d;
  logic              write_done_q, write_done_d;
  logic              read_done_q, read_done_d;
  logic [DATA_W-1:0] rd_mem [MEM_DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs  = bus.awvalid & bus.awready;
  assign w_hs   = bus.wvalid  & bus.wready;
  assign b_hs   = bus.bvalid  & bus.bready;
  assign ar_hs  = bus.arvalid & bus.arready;
  assign r_hs   = bus.rvalid  & bus.rready;
  assign rd_idx = IDX_W'(BASE_ADDR) + IDX_W'(beat_q);

  // Valids are pure functions of state and payloads depend only on state and
  // beat_q, so everything holds until the matching handshake moves the FSM.
  assign bus.awaddr  = BASE_ADDR;
  assign bus.awlen   = LAST_BEAT;
  assign bus.awsize  = SIZE;
  assign bus.awburst = BURST_INCR;
  assign bus.awvalid = (state_q == WR_ADDR);
  assign bus.wdata   = BASE_DATA + DATA_W'(beat_q);
  assign bus.wstrb   = '1;
  assign bus.wlast   = (beat_q == LAST_BEAT);
  assign bus.wvalid  = (state_q == WR_DATA);
  assign bus.bready  = (state_q == WR_RESP);
  assign bus.araddr  = BASE_ADDR;
  assign bus.arlen   = LAST_BEAT;
  assign bus.arsize  = SIZE;
  assign bus.arburst = BURST_INCR;
  assign bus.arvalid = (state_q == RD_ADDR);
  assign bus.rready  = (state_q == RD_DATA);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    resp_d       = resp_q;
    write_done_d = 1'b0;
    read_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        // Write has priority; a coincident read pulse is simply dropped.
        if (start_write)     state_d = WR_ADDR;
        else if (start_read) state_d = RD_ADDR;
      end
      WR_ADDR: if (aw_hs) state_d = WR_DATA;
      WR_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (bus.wlast) begin
            beat_d  = '0;
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          resp_d       = bus.bresp;
          write_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: begin
        if (r_hs) begin
          resp_d = bus.rresp;
          beat_d = beat_q + 8'd1;
          if (bus.rlast) begin
            beat_d      = '0;
            read_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge bus.aclk or negedge bus.areset_n) begin
    if (!bus.areset_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      resp_q       <= RESP_OKAY;
      write_done_q <= 1'b0;
      read_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      resp_q       <= resp_d;
      write_done_q <= write_done_d;
      read_done_q  <= read_done_d;
    end
  end

  // NOTE: this array is deliberately reset (built from flops, not a RAM
  // macro) so a reset mid-burst leaves no stale or partial beats visible.
  always_ff @(posedge bus.aclk or negedge bus.areset_n) begin
    if (!bus.areset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) rd_mem[i] <= '0;
    end else if (r_hs) begin
      rd_mem[rd_idx] <= bus.rdata;
    end
  end

  assign busy       = (state_q != IDLE);
  assign write_done = write_done_q;
  assign read_done  = read_done_q;
  assign resp       = resp_q;
  assign dbg_data   = rd_mem[IDX_W'(dbg_idx)];

endmodule

// File: rtl/axi_slave.sv
// ---------------------------------------------------------------------------
// axi_slave
// Memory-backed AXI4 target with a MEM_DEPTH-word buffer. Accepts one burst
// at a time; word index = (addr + beat) mod MEM_DEPTH. Always answers OKAY.
// Ports:
//   bus              axi_if slave modport (also supplies clock/reset)
//   dbg_idx/dbg_data combinational peek into the buffer
// ---------------------------------------------------------------------------
module axi_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  axi_if.slave              bus,
  input  logic [7:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  slv_state_e        state_q, state_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              unused_sideband;

  // Only a single INCR size is ever issued; upper address bits fall away in
  // the modulo-depth wrap.
  assign unused_sideband = ^{bus.awsize, bus.awburst, bus.arsize, bus.arburst,
                             bus.awaddr, bus.araddr};

  assign cur_idx = base_q + IDX_W'(beat_q);

  assign bus.awready = (state_q == S_IDLE);
  // AW wins a tie: arready drops while awvalid is up so no AR handshake can
  // complete in the same cycle and get lost.
  assign bus.arready = (state_q == S_IDLE) && !bus.awvalid;
  assign bus.wready  = (state_q == S_WDATA);
  assign bus.bvalid  = (state_q == S_BRESP);
  assign bus.bresp   = RESP_OKAY;
  assign bus.rvalid  = (state_q == S_RDATA);
  assign bus.rdata   = mem[cur_idx];
  assign bus.rresp   = RESP_OKAY;
  assign bus.rlast   = (beat_q == len_q);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (bus.awvalid) begin
          base_d  = IDX_W'(bus.awaddr);
          len_d   = bus.awlen;
          state_d = S_WDATA;
        end else if (bus.arvalid) begin
          base_d  = IDX_W'(bus.araddr);
          len_d   = bus.arlen;
          state_d = S_RDATA;
        end
      end
      S_WDATA: begin
        if (bus.wvalid) begin
          beat_d = beat_q + 8'd1;
          if (bus.wlast) state_d = S_BRESP;
        end
      end
      S_BRESP: if (bus.bready) state_d = S_IDLE;
      S_RDATA: begin
        if (bus.rready) begin
          beat_d = beat_q + 8'd1;
          if (bus.rlast) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bus.aclk or negedge bus.areset_n) begin
    if (!bus.areset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge bus.aclk or negedge bus.areset_n) begin
    if (!bus.areset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (state_q == S_WDATA && bus.wvalid) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (bus.wstrb[b]) mem[cur_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign dbg_data = mem[IDX_W'(dbg_idx)];

endmodule

// File: rtl/axi_burst_loopback.sv
// ---------------------------------------------------------------------------
// axi_burst_loopback
// Self-contained AXI4 loopback: axi_master and axi_slave joined by one
// internal axi_if.
// Ports:
//   aclk, areset_n          clock, asynchronous active-low reset
//   start_write, start_read one-cycle launch pulses
//   busy                    master not idle
//   write_done, read_done   one-cycle completion pulses
//   resp                    last bresp/rresp seen by the master
//   dbg_idx                 observation index
//   dbg_slave_data          slave buffer[dbg_idx]
//   dbg_master_data         master capture[dbg_idx]
// ---------------------------------------------------------------------------
module axi_burst_loopback
  import axi_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                BURST_LEN = DEF_BURST_LEN,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [DATA_W-1:0] BASE_DATA = DATA_W'(DEF_BASE_DATA),
  parameter int                MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              start_write,
  input  logic              start_read,
  output logic              busy,
  output logic              write_done,
  output logic              read_done,
  output logic [1:0]        resp,
  input  logic [7:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_slave_data,
  output logic [DATA_W-1:0] dbg_master_data
);

  axi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus (
    .aclk     (aclk),
    .areset_n (areset_n)
  );

  axi_master #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .BASE_ADDR (BASE_ADDR),
    .BASE_DATA (BASE_DATA),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_master (
    .bus         (bus),
    .start_write (start_write),
    .start_read  (start_read),
    .busy        (busy),
    .write_done  (write_done),
    .read_done   (read_done),
    .resp        (resp),
    .dbg_idx     (dbg_idx),
    .dbg_data    (dbg_master_data)
  );

  axi_slave #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_slave (
    .bus      (bus),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_slave_data)
  );

endmodule

// File: tb/tb_axi_burst_loopback.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_loopback
// Directed bench for axi_burst_loopback. A second axi_if instance drives a
// standalone axi_master against a bench-modelled slave that stalls the
// ready/valid lines, so payload stability under backpressure is observable.
// ---------------------------------------------------------------------------
module tb_axi_burst_loopback;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        start_write = 1'b0;
  logic        start_read = 1'b0;
  logic [7:0]  dbg_idx = 8'd0;
  logic        busy, write_done, read_done;
  logic [1:0]  resp;
  logic [31:0] dbg_slave_data, dbg_master_data;

  logic        m2_sw = 1'b0;
  logic        m2_sr = 1'b0;
  logic [7:0]  m2_idx = 8'd0;
  logic        m2_busy, m2_wd, m2_rd;
  logic [1:0]  m2_resp;
  logic [31:0] m2_dbg;

  int checks = 0;
  int failures = 0;
  int aw_cnt = 0;
  int ar_cnt = 0;

  // Hand-computed expectations for word indices 3..8 after the fixed burst.
  logic [31:0] exp_mem [6] = '{32'h0, 32'hdeadbeef, 32'hdeadbef0,
                               32'hdeadbef1, 32'hdeadbef2, 32'h0};
  logic [31:0] exp_wdata [4] = '{32'hdeadbeef, 32'hdeadbef0,
                                 32'hdeadbef1, 32'hdeadbef2};
  logic [31:0] r_vals [4] = '{32'h0badf00d, 32'h12345678,
                              32'hffffffff, 32'h00000001};
  int          w_stall [4] = '{2, 0, 1, 3};
  int          r_gap [4]   = '{1, 0, 2, 0};

  always #5 aclk = ~aclk;

  axi_burst_loopback dut (
    .aclk            (aclk),
    .areset_n        (areset_n),
    .start_write     (start_write),
    .start_read      (start_read),
    .busy            (busy),
    .write_done      (write_done),
    .read_done       (read_done),
    .resp            (resp),
    .dbg_idx         (dbg_idx),
    .dbg_slave_data  (dbg_slave_data),
    .dbg_master_data (dbg_master_data)
  );

  axi_if #(.ADDR_W(32), .DATA_W(32)) bus2 (.aclk(aclk), .areset_n(areset_n));

  axi_master u_m2 (
    .bus         (bus2),
    .start_write (m2_sw),
    .start_read  (m2_sr),
    .busy        (m2_busy),
    .write_done  (m2_wd),
    .read_done   (m2_rd),
    .resp        (m2_resp),
    .dbg_idx     (m2_idx),
    .dbg_data    (m2_dbg)
  );

  always @(posedge aclk) begin
    if (dut.bus.awvalid && dut.bus.awready) aw_cnt <= aw_cnt + 1;
    if (dut.bus.arvalid && dut.bus.arready) ar_cnt <= ar_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic w, input logic r);
    @(negedge aclk);
    start_write = w;
    start_read  = r;
    @(posedge aclk);
    #1;
    start_write = 1'b0;
    start_read  = 1'b0;
  endtask

  // Counts falling edges after the sampling edge until the done pulse shows.
  task automatic wait_done(input string tag, input bit is_write, input int max_cycles);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge aclk);
      n++;
      seen = is_write ? write_done : read_done;
    end
    check($sformatf("%s done_seen", tag), 64'(seen), 64'd1);
    check($sformatf("%s latency n=%0d", tag, n), 64'(n <= max_cycles), 64'd1);
  endtask

  task automatic check_window(input string tag, input bit slave_side);
    for (int k = 0; k < 6; k++) begin
      dbg_idx = 8'(3 + k);
      #1;
      check($sformatf("%s idx%0d", tag, 3 + k),
            slave_side ? dbg_slave_data : dbg_master_data, exp_mem[k]);
    end
  endtask

  initial begin
    bus2.awready = 1'b0; bus2.wready = 1'b0; bus2.bvalid = 1'b0;
    bus2.bresp   = 2'b00; bus2.arready = 1'b0; bus2.rvalid = 1'b0;
    bus2.rdata   = '0; bus2.rresp = 2'b00; bus2.rlast = 1'b0;

    // Reset state
    repeat (10) @(negedge aclk);
    dbg_idx = 8'd4;
    #1;
    check("rst awvalid", dut.bus.awvalid, 0);
    check("rst wvalid", dut.bus.wvalid, 0);
    check("rst arvalid", dut.bus.arvalid, 0);
    check("rst slave bvalid", dut.bus.bvalid, 0);
    check("rst slave rvalid", dut.bus.rvalid, 0);
    check("rst busy", busy, 0);
    check("rst done pulses", {write_done, read_done}, 0);
    check("rst resp", resp, 0);
    check("rst dbg_slave", dbg_slave_data, 0);
    check("rst dbg_master", dbg_master_data, 0);

    // Write, launched on the first edge after reset release
    @(negedge aclk);
    areset_n    = 1'b1;
    start_write = 1'b1;
    @(posedge aclk);
    #1;
    start_write = 1'b0;
    check("wr awvalid next cycle", dut.bus.awvalid, 1);
    check("wr busy", busy, 1);
    wait_done("wr1", 1'b1, 8);
    check("wr1 resp", resp, RESP_OKAY);
    check("wr1 busy after", busy, 0);
    check_window("wr1 slave", 1'b1);
    check("wr1 aw count", aw_cnt, 1);

    // Read back
    pulse(1'b0, 1'b1);
    check("rd arvalid next cycle", dut.bus.arvalid, 1);
    wait_done("rd1", 1'b0, 8);
    check("rd1 resp", resp, RESP_OKAY);
    check_window("rd1 master", 1'b0);
    check("rd1 ar count", ar_cnt, 1);

    // Coincident pulses: write wins, no AR
    pulse(1'b1, 1'b1);
    wait_done("both", 1'b1, 8);
    repeat (3) @(negedge aclk);
    check("both ar count", ar_cnt, 1);
    check("both aw count", aw_cnt, 2);
    check("both busy", busy, 0);

    // Read pulse while a write is in flight is ignored
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge aclk);
    start_read = 1'b1;
    @(posedge aclk);
    #1;
    start_read = 1'b0;
    wait_done("wr_mid", 1'b1, 6);
    check("wr_mid busy at done", busy, 0);
    repeat (3) @(negedge aclk);
    check("wr_mid busy after", busy, 0);
    check("wr_mid ar count", ar_cnt, 1);

    // Reset in the middle of a write burst
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge aclk);
    areset_n = 1'b0;
    dbg_idx  = 8'd4;
    #1;
    check("midrst busy", busy, 0);
    check("midrst wvalid", dut.bus.wvalid, 0);
    check("midrst slave cleared", dbg_slave_data, 0);
    check("midrst master cleared", dbg_master_data, 0);
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    pulse(1'b1, 1'b0);
    wait_done("recover", 1'b1, 8);
    check_window("recover slave", 1'b1);

    // Standalone master against a stalling bench slave
    pulse(1'b0, 1'b0);
    @(negedge aclk);
    m2_sw = 1'b1;
    @(posedge aclk);
    #1;
    m2_sw = 1'b0;
    check("m2 awsize", bus2.awsize, 3'd2);
    check("m2 awburst", bus2.awburst, BURST_INCR);
    for (int s = 0; s < 3; s++) begin
      @(negedge aclk);
      check("m2 aw hold", {bus2.awvalid, bus2.awaddr, bus2.awlen}, {1'b1, 32'h4, 8'd3});
    end
    bus2.awready = 1'b1;
    @(negedge aclk);
    bus2.awready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < w_stall[b]; s++) begin
        check($sformatf("m2 w%0d hold", b), {bus2.wvalid, bus2.wlast, bus2.wdata},
              {1'b1, (b == 3), exp_wdata[b]});
        @(negedge aclk);
      end
      check($sformatf("m2 w%0d beat", b), {bus2.wvalid, bus2.wlast, bus2.wstrb, bus2.wdata},
            {1'b1, (b == 3), 4'hf, exp_wdata[b]});
      bus2.wready = 1'b1;
      @(negedge aclk);
      bus2.wready = 1'b0;
    end
    check("m2 bready", bus2.bready, 1);
    repeat (2) @(negedge aclk);
    check("m2 busy in resp", m2_busy, 1);
    bus2.bvalid = 1'b1;
    bus2.bresp  = RESP_SLVERR;
    @(negedge aclk);
    bus2.bvalid = 1'b0;
    bus2.bresp  = RESP_OKAY;
    check("m2 write_done", m2_wd, 1);
    check("m2 bresp captured", m2_resp, RESP_SLVERR);

    @(negedge aclk);
    m2_sr = 1'b1;
    @(posedge aclk);
    #1;
    m2_sr = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge aclk);
      check("m2 ar hold", {bus2.arvalid, bus2.araddr, bus2.arlen}, {1'b1, 32'h4, 8'd3});
    end
    bus2.arready = 1'b1;
    @(negedge aclk);
    bus2.arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < r_gap[b]; s++) begin
        @(negedge aclk);
        check($sformatf("m2 rready gap%0d", b), bus2.rready, 1);
      end
      bus2.rvalid = 1'b1;
      bus2.rdata  = r_vals[b];
      bus2.rlast  = (b == 3);
      @(negedge aclk);
      bus2.rvalid = 1'b0;
      bus2.rlast  = 1'b0;
    end
    check("m2 read_done", m2_rd, 1);
    check("m2 busy after read", m2_busy, 0);
    check("m2 rresp captured", m2_resp, RESP_OKAY);
    for (int k = 0; k < 6; k++) begin
      m2_idx = 8'(3 + k);
      #1;
      check($sformatf("m2 capture idx%0d", 3 + k), m2_dbg,
            (k == 0 || k == 5) ? 32'h0 : r_vals[k - 1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
